// File: rtl/demosaic_mem_arb_if.sv
// Requester / plane-memory signal bundle for demosaic_mem_arb.
// The wait counters exist only when DEMOSAIC_ARB_STATS_EN is defined.
interface demosaic_mem_arb_if #(
    parameter int AW = 14,
    parameter int DW = 8
);
    logic          req0;
    logic          we0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          gnt0;
    logic          rvalid0;

    logic          req1;
    logic          we1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          gnt1;
    logic          rvalid1;

    logic [DW-1:0] rdata_o;

    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

`ifdef DEMOSAIC_ARB_STATS_EN
    logic [15:0]   wait_cnt0;
    logic [15:0]   wait_cnt1;
`endif

    // Arbiter side
    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_rdata,
        output gnt0, rvalid0, gnt1, rvalid1, rdata_o,
        output mem_wr, mem_addr, mem_wdata
`ifdef DEMOSAIC_ARB_STATS_EN
        , output wait_cnt0, wait_cnt1
`endif
    );

    // Requester / memory side
    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_rdata,
        input  gnt0, rvalid0, gnt1, rvalid1, rdata_o,
        input  mem_wr, mem_addr, mem_wdata
`ifdef DEMOSAIC_ARB_STATS_EN
        , input wait_cnt0, wait_cnt1
`endif
    );
endinterface

// File: rtl/demosaic_mem_arb.sv
// Round-robin, burst-bounded arbiter sharing one colour-plane memory port between the
// capture writer (0) and the interpolation engine (1). Optional: DEMOSAIC_ARB_STATS_EN.
module demosaic_mem_arb #(
    parameter int AW        = 14,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    demosaic_mem_arb_if.slave bus
);
    typedef enum logic {
        OWN_R0 = 1'b0,
        OWN_R1 = 1'b1
    } owner_e;

    localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

    owner_e        owner_q, owner_d;
    logic [3:0]    burst_cnt_q, burst_cnt_d;
    logic          rvalid0_q, rvalid0_d;
    logic          rvalid1_q, rvalid1_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic          gnt0, gnt1, any_gnt, sel1;
    owner_e        granted;
    logic [AW-1:0] addr_mux;
    logic [DW-1:0] wdata_mux;

    // burst_cnt == 0 only after an idle cycle or reset, so it doubles as "no burst running"
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            if (bus.req0 && bus.req1) begin
                if (burst_cnt_q == '0) begin
                    gnt0 = (owner_q == OWN_R1);
                    gnt1 = (owner_q == OWN_R0);
                end else if (burst_cnt_q < BURST_MAX) begin
                    gnt0 = (owner_q == OWN_R0);
                    gnt1 = (owner_q == OWN_R1);
                end else begin
                    gnt0 = (owner_q == OWN_R1);
                    gnt1 = (owner_q == OWN_R0);
                end
            end else begin
                gnt0 = bus.req0;
                gnt1 = bus.req1;
            end
        end
    end

    assign any_gnt = gnt0 | gnt1;

    always_comb begin
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        granted     = gnt1 ? OWN_R1 : OWN_R0;
        if (any_gnt) begin
            if (granted == owner_q) begin
                burst_cnt_d = (burst_cnt_q >= BURST_MAX) ? BURST_MAX : burst_cnt_q + 4'd1;
            end else begin
                owner_d     = granted;
                burst_cnt_d = 4'd1;
            end
        end else begin
            burst_cnt_d = '0;
        end
    end

    // With no grant the select falls back to the last granted requester (owner)
    assign sel1      = gnt1 | (~gnt0 & (owner_q == OWN_R1));
    assign addr_mux  = sel1 ? bus.addr1  : bus.addr0;
    assign wdata_mux = sel1 ? bus.wdata1 : bus.wdata0;

    // Each term is masked by its own grant, so X on an idle requester's we cannot leak
    assign bus.mem_wr    = (gnt0 & bus.we0) | (gnt1 & bus.we1);
    assign bus.mem_addr  = addr_mux;
    assign bus.mem_wdata = wdata_mux;

    always_comb begin
        rvalid0_d = gnt0 & ~bus.we0;
        rvalid1_d = gnt1 & ~bus.we1;
        rdata_d   = rdata_q;
        if (rvalid0_d || rvalid1_d) begin
            rdata_d = bus.mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q     <= OWN_R1;
            burst_cnt_q <= '0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            rdata_q     <= '0;
        end else begin
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
            rdata_q     <= rdata_d;
        end
    end

    assign bus.gnt0    = gnt0;
    assign bus.gnt1    = gnt1;
    assign bus.rvalid0 = rvalid0_q;
    assign bus.rvalid1 = rvalid1_q;
    assign bus.rdata_o = rdata_q;

`ifdef DEMOSAIC_ARB_STATS_EN
    logic [15:0] wait_cnt0_q, wait_cnt0_d;
    logic [15:0] wait_cnt1_q, wait_cnt1_d;

    always_comb begin
        wait_cnt0_d = wait_cnt0_q;
        wait_cnt1_d = wait_cnt1_q;
        if (bus.req0 && !gnt0 && (wait_cnt0_q != '1)) begin
            wait_cnt0_d = wait_cnt0_q + 16'd1;
        end
        if (bus.req1 && !gnt1 && (wait_cnt1_q != '1)) begin
            wait_cnt1_d = wait_cnt1_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt0_q <= '0;
            wait_cnt1_q <= '0;
        end else begin
            wait_cnt0_q <= wait_cnt0_d;
            wait_cnt1_q <= wait_cnt1_d;
        end
    end

    assign bus.wait_cnt0 = wait_cnt0_q;
    assign bus.wait_cnt1 = wait_cnt1_q;
`endif

    a_gnt_onehot: assert property (@(posedge clk) !(gnt0 && gnt1));
    a_wr_needs_gnt: assert property (@(posedge clk) bus.mem_wr |-> any_gnt);
endmodule

// File: tb/tb_demosaic_mem_arb.sv
// Self-checking bench for demosaic_mem_arb: vector table, directed corner sequences,
// and randomized traffic against a rule-level arbitration/memory model.
module tb_demosaic_mem_arb;
    localparam int AW   = 14;
    localparam int DW   = 8;
    localparam int MAXB = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    demosaic_mem_arb_if #(.AW(AW), .DW(DW)) bus ();

    demosaic_mem_arb #(.AW(AW), .DW(DW), .MAX_BURST(MAXB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Plane memory: samples on the falling edge, combinational read
    logic [DW-1:0] mem [0:16383];
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;

    always @(negedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (bus.mem_wr === 1'b1) mem[bus.mem_addr] <= bus.mem_wdata;
    end
    assign bus.mem_rdata = mem[bus.mem_addr];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // A write strobe must always coincide with a grant and never appear under reset
    always @(negedge clk) begin
        if (bus.mem_wr !== 1'b0) begin
            checks++;
            if (reset !== 1'b0 || !(bus.gnt0 === 1'b1 || bus.gnt1 === 1'b1)) begin
                errors++;
                $display("FAIL spurious_write mem_wr=%b gnt0=%b gnt1=%b reset=%b t=%0t",
                         bus.mem_wr, bus.gnt0, bus.gnt1, reset, $time);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic          rst;
        logic          r0, w0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic          r1, w1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic          eg0, eg1, ewr;
        logic [AW-1:0] eaddr;
        logic [DW-1:0] edata;
    } vec_t;

    function automatic vec_t mk(input int rst, r0, w0, a0, d0, r1, w1, a1, d1,
                                input int eg0, eg1, ewr, eaddr, edata);
        vec_t v;
        v.rst = 1'(rst);
        v.r0 = 1'(r0); v.w0 = 1'(w0); v.a0 = AW'(a0); v.d0 = DW'(d0);
        v.r1 = 1'(r1); v.w1 = 1'(w1); v.a1 = AW'(a1); v.d1 = DW'(d1);
        v.eg0 = 1'(eg0); v.eg1 = 1'(eg1); v.ewr = 1'(ewr);
        v.eaddr = AW'(eaddr); v.edata = DW'(edata);
        return v;
    endfunction

    task automatic set_in(input int r0, w0, a0, d0, r1, w1, a1, d1);
        bus.req0 = 1'(r0); bus.we0 = 1'(w0); bus.addr0 = AW'(a0); bus.wdata0 = DW'(d0);
        bus.req1 = 1'(r1); bus.we1 = 1'(w1); bus.addr1 = AW'(a1); bus.wdata1 = DW'(d1);
    endtask

    // One cycle: inputs change just after the rising edge, outputs sampled mid-high-phase
    task automatic cyc(input int r0, w0, a0, d0, r1, w1, a1, d1);
        @(posedge clk); #1;
        set_in(r0, w0, a0, d0, r1, w1, a1, d1);
        #3;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        #3;
    endtask

    task automatic preload(input int a, input int d);
        pre_addr = AW'(a);
        pre_data = DW'(d);
        pre_we   = 1'b1;
        @(negedge clk); #1;
        pre_we   = 1'b0;
    endtask

    vec_t          vt[$];
    int            pat[9]  = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    int            rpat[4] = '{0, 0, 0, 1};

    // Random-phase stimulus and reference-model state
    logic          r0, w0, r1, w1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    logic          hold0, hold1, exp_rv0, exp_rv1, ewr;
    logic [DW-1:0] exp_rd;
    logic [DW-1:0] shadow [0:15];
    int            eg, last, run;

    initial begin
        reset  = 1'b1;
        pre_we = 1'b0;
        pre_addr = '0;
        pre_data = '0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #3;
        chk("rst_rvalid0", bus.rvalid0, 0);
        chk("rst_rvalid1", bus.rvalid1, 0);
        chk("rst_rdata",   bus.rdata_o, 0);
        chk("rst_gnt0",    bus.gnt0, 0);
        chk("rst_gnt1",    bus.gnt1, 0);
        chk("rst_mem_wr",  bus.mem_wr, 0);
`ifdef DEMOSAIC_ARB_STATS_EN
        chk("rst_wait0", bus.wait_cnt0, 0);
        chk("rst_wait1", bus.wait_cnt1, 0);
`endif

        // ---- vector table: solo writer burst, then contention from fresh reset ----
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++)
            vt.push_back(mk(0, 1, 1, i, 8'h10 + i, 0, 0, 0, 0,  1, 0, 1, i, 8'h10 + i));
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
        for (int i = 0; i < 9; i++)
            vt.push_back(mk(0, 1, 0, 100, 8'h00, 1, 1, 200, 8'h77,
                            pat[i] == 0, pat[i] == 1, pat[i] == 1,
                            (pat[i] == 1) ? 200 : 100, (pat[i] == 1) ? 8'h77 : 8'h00));

        for (int i = 0; i < vt.size(); i++) begin
            @(posedge clk); #1;
            reset = vt[i].rst;
            bus.req0 = vt[i].r0; bus.we0 = vt[i].w0; bus.addr0 = vt[i].a0; bus.wdata0 = vt[i].d0;
            bus.req1 = vt[i].r1; bus.we1 = vt[i].w1; bus.addr1 = vt[i].a1; bus.wdata1 = vt[i].d1;
            #3;
            chk($sformatf("vec%0d_gnt0", i), bus.gnt0, vt[i].eg0);
            chk($sformatf("vec%0d_gnt1", i), bus.gnt1, vt[i].eg1);
            chk($sformatf("vec%0d_mem_wr", i), bus.mem_wr, vt[i].ewr);
            if (vt[i].eg0 || vt[i].eg1) begin
                chk($sformatf("vec%0d_mem_addr", i), bus.mem_addr, vt[i].eaddr);
                chk($sformatf("vec%0d_mem_wdata", i), bus.mem_wdata, vt[i].edata);
            end
        end
        reset = 1'b0;

        // ---- requester 1 reads a preloaded word ----
        do_reset();
        preload(129, 8'hA5);
        cyc(0, 0, 0, 0, 1, 0, 129, 0);
        chk("rd_gnt1", bus.gnt1, 1);
        chk("rd_gnt0", bus.gnt0, 0);
        chk("rd_mem_wr", bus.mem_wr, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("rd_rvalid1", bus.rvalid1, 1);
        chk("rd_rdata", bus.rdata_o, 8'hA5);
        chk("rd_rvalid0", bus.rvalid0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("rd_rvalid1_once", bus.rvalid1, 0);

        // ---- write then read of the same address from the two requesters ----
        cyc(1, 1, 5, 8'h55, 1, 0, 5, 0);
        chk("wr_rd_gnt0", bus.gnt0, 1);
        chk("wr_rd_mem_wr", bus.mem_wr, 1);
        chk("wr_rd_addr", bus.mem_addr, 5);
        chk("wr_rd_wdata", bus.mem_wdata, 8'h55);
        cyc(0, 0, 0, 0, 1, 0, 5, 0);
        chk("wr_rd_gnt1", bus.gnt1, 1);
        chk("wr_rd_no_rv0", bus.rvalid0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("wr_rd_rvalid1", bus.rvalid1, 1);
        chk("wr_rd_rdata", bus.rdata_o, 8'h55);

        // ---- reset in the 3rd cycle of a requester-1 read burst ----
        cyc(0, 0, 0, 0, 1, 0, 10, 0);
        chk("rb_gnt1_a", bus.gnt1, 1);
        cyc(0, 0, 0, 0, 1, 0, 11, 0);
        chk("rb_gnt1_b", bus.gnt1, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        set_in(1, 1, 7, 8'h99, 1, 0, 12, 0);
        #3;
        chk("rb_rst_mem_wr", bus.mem_wr, 0);
        chk("rb_rst_rvalid1", bus.rvalid1, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        #3;
        chk("rb_after_rvalid1", bus.rvalid1, 0);
        chk("rb_after_gnt0", bus.gnt0, 1);
        chk("rb_after_gnt1", bus.gnt1, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 1, 7, 8'h99, 1, 0, 12, 0);
            chk($sformatf("rb_seq%0d_gnt0", i), bus.gnt0, rpat[i] == 0);
            chk($sformatf("rb_seq%0d_gnt1", i), bus.gnt1, rpat[i] == 1);
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 0);

`ifdef DEMOSAIC_ARB_STATS_EN
        // ---- wait counters under 20 cycles of full contention ----
        do_reset();
        chk("st_wait0_clr", bus.wait_cnt0, 0);
        chk("st_wait1_clr", bus.wait_cnt1, 0);
        repeat (20) cyc(1, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("st_wait0", bus.wait_cnt0, 8);
        chk("st_wait1", bus.wait_cnt1, 12);
`endif

        // ---- randomized traffic against the rule-level model ----
        do_reset();
        for (int i = 0; i < 16; i++) begin
            shadow[i] = DW'($urandom);
            preload(i, shadow[i]);
        end
        last = 1; run = 0;
        hold0 = 1'b0; hold1 = 1'b0; exp_rv0 = 1'b0; exp_rv1 = 1'b0; exp_rd = '0;
        r0 = 1'b0; w0 = 1'b0; a0 = '0; d0 = '0;
        r1 = 1'b0; w1 = 1'b0; a1 = '0; d1 = '0;

        for (int n = 0; n < 400; n++) begin
            // A denied requester holds its request or cancels it; otherwise pick a fresh one
            if (hold0) begin
                if ($urandom_range(0, 9) == 0) r0 = 1'b0;
            end else begin
                r0 = ($urandom_range(0, 9) < 6);
                w0 = 1'($urandom_range(0, 1));
                a0 = AW'($urandom_range(0, 15));
                d0 = DW'($urandom);
            end
            if (hold1) begin
                if ($urandom_range(0, 9) == 0) r1 = 1'b0;
            end else begin
                r1 = ($urandom_range(0, 9) < 6);
                w1 = 1'($urandom_range(0, 1));
                a1 = AW'($urandom_range(0, 15));
                d1 = DW'($urandom);
            end
            if (!r0 && $urandom_range(0, 3) == 0) w0 = 1'bx;
            if (!r1 && $urandom_range(0, 3) == 0) w1 = 1'bx;

            if (r0 && r1) begin
                if (run == 0)          eg = 1 - last;
                else if (run < MAXB)   eg = last;
                else                   eg = 1 - last;
            end else if (r0) eg = 0;
            else if (r1)     eg = 1;
            else             eg = -1;

            @(posedge clk); #1;
            bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
            bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
            #3;

            ewr = (eg == 0) ? w0 : (eg == 1) ? w1 : 1'b0;
            chk("rnd_gnt0", bus.gnt0, eg == 0);
            chk("rnd_gnt1", bus.gnt1, eg == 1);
            chk("rnd_mem_wr", bus.mem_wr, ewr);
            if (eg >= 0) begin
                chk("rnd_mem_addr", bus.mem_addr, (eg == 1) ? a1 : a0);
                chk("rnd_mem_wdata", bus.mem_wdata, (eg == 1) ? d1 : d0);
            end
            chk("rnd_rvalid0", bus.rvalid0, exp_rv0);
            chk("rnd_rvalid1", bus.rvalid1, exp_rv1);
            if (exp_rv0 || exp_rv1) chk("rnd_rdata", bus.rdata_o, exp_rd);

            exp_rv0 = 1'b0;
            exp_rv1 = 1'b0;
            if (eg >= 0) begin
                if (eg == last) run = (run < MAXB) ? run + 1 : MAXB;
                else begin
                    last = eg;
                    run  = 1;
                end
                if (eg == 0) begin
                    if (w0) shadow[a0[3:0]] = d0;
                    else begin exp_rv0 = 1'b1; exp_rd = shadow[a0[3:0]]; end
                end else begin
                    if (w1) shadow[a1[3:0]] = d1;
                    else begin exp_rv1 = 1'b1; exp_rd = shadow[a1[3:0]]; end
                end
            end else begin
                run = 0;
            end
            hold0 = r0 && (eg != 0);
            hold1 = r1 && (eg != 1);
        end

        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("rnd_tail_rvalid0", bus.rvalid0, exp_rv0);
        chk("rnd_tail_rvalid1", bus.rvalid1, exp_rv1);
        if (exp_rv0 || exp_rv1) chk("rnd_tail_rdata", bus.rdata_o, exp_rd);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
